// File: rtl/kgp_pkg.sv
// Shared encodings and default widths for the KGP_RISC memory arbiter.
package kgp_pkg;
  localparam int KGP_ADDR_W = 10;
  localparam int KGP_DATA_W = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;
endpackage

// File: rtl/kgp_mem_arbiter_if.sv
// Requester and RAM-side signals of the memory arbiter; slave = arbiter side.
interface kgp_mem_arbiter_if import kgp_pkg::*; #(
  parameter int ADDR_W = KGP_ADDR_W,
  parameter int DATA_W = KGP_DATA_W
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
    output if_gnt, if_done, if_rdata, d_gnt, d_done, d_rdata,
           mem_en, mem_we, mem_addr, mem_din
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
    input  if_gnt, if_done, if_rdata, d_gnt, d_done, d_rdata,
           mem_en, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/kgp_arb_prio.sv
// Winner select between fetch and data, with the fetch starvation counter.
module kgp_arb_prio #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic can_issue,
  input  logic if_req,
  input  logic d_req,
  output logic if_win,
  output logic d_win
);
  localparam logic [4:0] SMAX = 5'(STARVE_MAX);

  logic [3:0] starve_q, starve_d;
  logic       force_if;

  always_comb begin
    force_if = (STARVE_MAX != 0) && ({1'b0, starve_q} >= SMAX);
    d_win    = can_issue && d_req && !(if_req && force_if);
    if_win   = can_issue && if_req && !d_win;
    starve_d = starve_q;
    // Only losses at an arbitration point count; saturate rather than wrap.
    if (if_win)
      starve_d = '0;
    else if (can_issue && if_req && d_win && starve_q != 4'hF)
      starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end
endmodule

// File: rtl/kgp_mem_arbiter.sv
// Shares the single-port KGP_RISC block RAM between fetch and load/store.
// Define KGP_ARB_PERF_EN to add the if_stall_cnt/d_stall_cnt counters.
module kgp_mem_arbiter import kgp_pkg::*; #(
  parameter int ADDR_W     = KGP_ADDR_W,
  parameter int DATA_W     = KGP_DATA_W,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  kgp_mem_arbiter_if.slave bus
`ifdef KGP_ARB_PERF_EN
  ,
  output logic [31:0]      if_stall_cnt,
  output logic [31:0]      d_stall_cnt
`endif
);
  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              owner_we_q, owner_we_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              done_cyc, can_issue, fin;
  logic              if_win, d_win;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] din_mux;

  always_comb begin
    done_cyc  = (state_q == ST_WAIT) && (lat_q == LAT_LAST);
    can_issue = !reset && ((state_q == ST_IDLE) || done_cyc);
    // Reset on the done cycle still abandons the access.
    fin       = done_cyc && !reset;
  end

  kgp_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk       (clk),
    .reset     (reset),
    .can_issue (can_issue),
    .if_req    (bus.if_req),
    .d_req     (bus.d_req),
    .if_win    (if_win),
    .d_win     (d_win)
  );

  always_comb begin
    addr_mux = '0;
    din_mux  = '0;
    if (d_win) begin
      addr_mux = bus.d_addr;
      din_mux  = bus.d_wdata;
    end else if (if_win) begin
      addr_mux = bus.if_addr;
    end
    bus.if_gnt   = if_win;
    bus.d_gnt    = d_win;
    bus.mem_en   = if_win | d_win;
    bus.mem_we   = d_win & bus.d_we;
    bus.mem_addr = addr_mux;
    bus.mem_din  = din_mux;
    bus.if_done  = fin && (owner_q == OWN_IF);
    bus.d_done   = fin && (owner_q == OWN_D);
    bus.if_rdata = bus.if_done ? bus.mem_dout : '0;
    bus.d_rdata  = (bus.d_done && !owner_we_q) ? bus.mem_dout : '0;
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    owner_we_d = owner_we_q;
    lat_d      = lat_q;
    if (if_win || d_win) begin
      state_d    = ST_WAIT;
      owner_d    = d_win ? OWN_D : OWN_IF;
      owner_we_d = d_win & bus.d_we;
      lat_d      = '0;
    end else if (state_q == ST_WAIT) begin
      if (done_cyc) begin
        state_d    = ST_IDLE;
        owner_d    = OWN_NONE;
        owner_we_d = 1'b0;
        lat_d      = '0;
      end else begin
        lat_d = lat_q + LAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_NONE;
      owner_we_q <= 1'b0;
      lat_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      owner_we_q <= owner_we_d;
      lat_q      <= lat_d;
    end
  end

`ifdef KGP_ARB_PERF_EN
  logic [31:0] if_stall_q, if_stall_d, d_stall_q, d_stall_d;

  always_comb begin
    if_stall_d = if_stall_q + ((bus.if_req && !if_win) ? 32'd1 : 32'd0);
    d_stall_d  = d_stall_q  + ((bus.d_req  && !d_win)  ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_stall_q <= '0;
      d_stall_q  <= '0;
    end else begin
      if_stall_q <= if_stall_d;
      d_stall_q  <= d_stall_d;
    end
  end

  assign if_stall_cnt = if_stall_q;
  assign d_stall_cnt  = d_stall_q;
`endif
endmodule

// File: tb/tb_kgp_mem_arbiter.sv
// Directed bench: MEM_LAT=1 vector table plus MEM_LAT=3 latency/reset sequences.
module tb_kgp_mem_arbiter;
  logic clk = 1'b0;
  logic rst1, rst3;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  kgp_mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) b1 ();
  kgp_mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) b3 ();

`ifdef KGP_ARB_PERF_EN
  logic [31:0] if_st1, d_st1, if_st3, d_st3;
`endif

  kgp_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u1 (
    .clk(clk), .reset(rst1), .bus(b1)
`ifdef KGP_ARB_PERF_EN
    , .if_stall_cnt(if_st1), .d_stall_cnt(d_st1)
`endif
  );

  kgp_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u3 (
    .clk(clk), .reset(rst3), .bus(b3)
`ifdef KGP_ARB_PERF_EN
    , .if_stall_cnt(if_st3), .d_stall_cnt(d_st3)
`endif
  );

  // Block RAM models: registered read (read-first), latency 1 and 3.
  logic [31:0] mem1 [1024];
  logic [31:0] mem3 [1024];
  logic [31:0] dout1 = '0;
  logic [31:0] p0 = '0, p1 = '0, p2 = '0;

  always @(posedge clk) begin
    if (b1.mem_en) begin
      dout1 <= mem1[b1.mem_addr];
      if (b1.mem_we) mem1[b1.mem_addr] <= b1.mem_din;
    end
    if (b3.mem_en) begin
      p0 <= mem3[b3.mem_addr];
      if (b3.mem_we) mem3[b3.mem_addr] <= b3.mem_din;
    end
    p1 <= p0;
    p2 <= p1;
  end

  assign b1.mem_dout = dout1;
  assign b3.mem_dout = p2;

  typedef struct {
    logic ir; logic [9:0] ia; logic dr; logic dw; logic [9:0] da; logic [31:0] dd;
    logic eig; logic edg; logic een; logic ewe; logic [9:0] ea; logic [31:0] edin;
    logic eid; logic [31:0] eir; logic edd; logic [31:0] edr;
  } vec_t;

  vec_t tv [15];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic idle_inputs();
    b1.if_req = 0; b1.if_addr = '0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = '0; b1.d_wdata = '0;
    b3.if_req = 0; b3.if_addr = '0; b3.d_req = 0; b3.d_we = 0; b3.d_addr = '0; b3.d_wdata = '0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem1[i] = 32'h1000_0000 + 32'(i);
      mem3[i] = 32'h3000_0000 + 32'(i);
    end
    //        ir ia   dr dw da  dd            | ig dg en we ea  din           | id ird          dd drd
    tv[0]  = '{1, 5,  0, 0, 0,  0,             1, 0, 1, 0, 5,  0,             0, 0,            0, 0};
    tv[1]  = '{1, 6,  0, 0, 0,  0,             1, 0, 1, 0, 6,  0,             1, 32'h10000005, 0, 0};
    tv[2]  = '{1, 7,  0, 0, 0,  0,             1, 0, 1, 0, 7,  0,             1, 32'h10000006, 0, 0};
    tv[3]  = '{0, 0,  0, 0, 0,  0,             0, 0, 0, 0, 0,  0,             1, 32'h10000007, 0, 0};
    tv[4]  = '{0, 0,  0, 0, 0,  0,             0, 0, 0, 0, 0,  0,             0, 0,            0, 0};
    tv[5]  = '{1, 20, 1, 0, 9,  0,             0, 1, 1, 0, 9,  0,             0, 0,            0, 0};
    tv[6]  = '{1, 20, 1, 0, 9,  0,             0, 1, 1, 0, 9,  0,             0, 0,            1, 32'h10000009};
    tv[7]  = '{1, 20, 1, 0, 9,  0,             0, 1, 1, 0, 9,  0,             0, 0,            1, 32'h10000009};
    tv[8]  = '{1, 20, 1, 0, 9,  0,             0, 1, 1, 0, 9,  0,             0, 0,            1, 32'h10000009};
    tv[9]  = '{1, 20, 1, 0, 9,  0,             1, 0, 1, 0, 20, 0,             0, 0,            1, 32'h10000009};
    tv[10] = '{1, 20, 1, 0, 9,  0,             0, 1, 1, 0, 9,  0,             1, 32'h10000014, 0, 0};
    tv[11] = '{0, 0,  1, 1, 3,  32'hDEADBEEF,  0, 1, 1, 1, 3,  32'hDEADBEEF,  0, 0,            1, 32'h10000009};
    tv[12] = '{0, 0,  1, 0, 3,  0,             0, 1, 1, 0, 3,  0,             0, 0,            1, 0};
    tv[13] = '{0, 0,  0, 0, 0,  0,             0, 0, 0, 0, 0,  0,             0, 0,            1, 32'hDEADBEEF};
    tv[14] = '{0, 0,  0, 0, 0,  0,             0, 0, 0, 0, 0,  0,             0, 0,            0, 0};

    idle_inputs();
    rst1 = 1; rst3 = 1;
    repeat (3) @(negedge clk);
    #3;
    chk("rst.if_gnt",  32'(b1.if_gnt), 0);
    chk("rst.d_gnt",   32'(b1.d_gnt),  0);
    chk("rst.mem_en",  32'(b1.mem_en), 0);
    chk("rst.mem_we",  32'(b1.mem_we), 0);
    chk("rst.if_done", 32'(b1.if_done), 0);
    chk("rst.d_done",  32'(b1.d_done), 0);
    chk("rst.d_rdata", b1.d_rdata, 0);
    chk("rst3.mem_en", 32'(b3.mem_en), 0);
    @(negedge clk);
    rst1 = 0; rst3 = 0;

    for (int i = 0; i < 15; i++) begin
      b1.if_req = tv[i].ir; b1.if_addr = tv[i].ia;
      b1.d_req = tv[i].dr;  b1.d_we = tv[i].dw; b1.d_addr = tv[i].da; b1.d_wdata = tv[i].dd;
      #3;
      chk($sformatf("v%0d.if_gnt", i),   32'(b1.if_gnt),   32'(tv[i].eig));
      chk($sformatf("v%0d.d_gnt", i),    32'(b1.d_gnt),    32'(tv[i].edg));
      chk($sformatf("v%0d.mem_en", i),   32'(b1.mem_en),   32'(tv[i].een));
      chk($sformatf("v%0d.mem_we", i),   32'(b1.mem_we),   32'(tv[i].ewe));
      chk($sformatf("v%0d.mem_addr", i), 32'(b1.mem_addr), 32'(tv[i].ea));
      chk($sformatf("v%0d.mem_din", i),  b1.mem_din,       tv[i].edin);
      chk($sformatf("v%0d.if_done", i),  32'(b1.if_done),  32'(tv[i].eid));
      chk($sformatf("v%0d.if_rdata", i), b1.if_rdata,      tv[i].eir);
      chk($sformatf("v%0d.d_done", i),   32'(b1.d_done),   32'(tv[i].edd));
      chk($sformatf("v%0d.d_rdata", i),  b1.d_rdata,       tv[i].edr);
`ifdef KGP_ARB_PERF_EN
      if (i == 10) begin
        chk("perf.if_stall", if_st1, 32'd4);
        chk("perf.d_stall",  d_st1,  32'd1);
      end
`endif
      @(negedge clk);
    end

    // MEM_LAT=3: load at t, fetch held from t+1 is granted only at t+3.
    b3.d_req = 1; b3.d_addr = 10'd12; #3;
    chk("l3.t.d_gnt", 32'(b3.d_gnt), 1);
    chk("l3.t.addr",  32'(b3.mem_addr), 12);
    @(negedge clk); b3.d_req = 0; b3.if_req = 1; b3.if_addr = 10'd4; #3;
    chk("l3.t1.if_gnt", 32'(b3.if_gnt), 0);
    chk("l3.t1.mem_en", 32'(b3.mem_en), 0);
    chk("l3.t1.d_done", 32'(b3.d_done), 0);
    @(negedge clk); #3;
    chk("l3.t2.if_gnt", 32'(b3.if_gnt), 0);
    chk("l3.t2.d_done", 32'(b3.d_done), 0);
    @(negedge clk); #3;
    chk("l3.t3.d_done",  32'(b3.d_done), 1);
    chk("l3.t3.d_rdata", b3.d_rdata, 32'h3000000C);
    chk("l3.t3.if_gnt",  32'(b3.if_gnt), 1);
    chk("l3.t3.addr",    32'(b3.mem_addr), 4);
    @(negedge clk); b3.if_req = 0; #3;
    chk("l3.t4.if_done", 32'(b3.if_done), 0);
    @(negedge clk); #3;
    chk("l3.t5.if_done", 32'(b3.if_done), 0);
    @(negedge clk); #3;
    chk("l3.t6.if_done",  32'(b3.if_done), 1);
    chk("l3.t6.if_rdata", b3.if_rdata, 32'h30000004);

    // Reset mid-WAIT abandons the load; next request is served normally.
    @(negedge clk); b3.d_req = 1; b3.d_addr = 10'd13; #3;
    chk("r3.t.d_gnt", 32'(b3.d_gnt), 1);
    @(negedge clk); b3.d_req = 0; rst3 = 1; #3;
    chk("r3.t1.d_done", 32'(b3.d_done), 0);
    @(negedge clk); rst3 = 0; #3;
    chk("r3.t2.d_done",  32'(b3.d_done), 0);
    chk("r3.t2.d_gnt",   32'(b3.d_gnt), 0);
    chk("r3.t2.if_gnt",  32'(b3.if_gnt), 0);
    chk("r3.t2.mem_en",  32'(b3.mem_en), 0);
    chk("r3.t2.mem_we",  32'(b3.mem_we), 0);
    chk("r3.t2.addr",    32'(b3.mem_addr), 0);
    chk("r3.t2.d_rdata", b3.d_rdata, 0);
    chk("r3.t2.if_done", 32'(b3.if_done), 0);
    @(negedge clk); b3.if_req = 1; b3.if_addr = 10'd8; #3;
    chk("r3.t3.d_done", 32'(b3.d_done), 0);
    chk("r3.t3.if_gnt", 32'(b3.if_gnt), 1);
    chk("r3.t3.addr",   32'(b3.mem_addr), 8);
    @(negedge clk); b3.if_req = 0; #3;
    chk("r3.t4.d_done", 32'(b3.d_done), 0);
    @(negedge clk); #3;
    chk("r3.t5.if_done", 32'(b3.if_done), 0);
    @(negedge clk); #3;
    chk("r3.t6.if_done",  32'(b3.if_done), 1);
    chk("r3.t6.if_rdata", b3.if_rdata, 32'h30000008);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
